// File: rtl/layer2_output_stage_if.sv
// ---------------------------------------------------------------------------
// layer2_output_stage_if
// Handshake bundle between the layer-2 neuron array, the output stage and
// the readout consumer.
//   in_valid/in_ready/in_bits           : shot vector from the neuron LUTs
//   out_valid/out_ready/out_class/
//   out_popcount                        : voted result to the readout side
// master : environment side (drives the shot vector and out_ready)
// slave  : the output stage itself
// ---------------------------------------------------------------------------
interface layer2_output_stage_if #(
    parameter int N_NEURONS = 16
);
    localparam int PW = $clog2(N_NEURONS + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [N_NEURONS-1:0] in_bits;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_class;
    logic [PW-1:0]        out_popcount;

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_class, out_popcount
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_class, out_popcount
    );
endinterface

// File: rtl/layer2_output_stage.sv
// ---------------------------------------------------------------------------
// layer2_output_stage
// Registered stage behind the layer-2 neuron LUTs. Each accepted shot vector
// is popcounted and majority-voted (class = popcount >= THRESH). Saturating
// counters track transferred shots and class-1 shots.
// Pipeline: 2-entry FIFO -> S1 (popcount) -> S2 (popcount + class).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : input and output valid/ready handshakes
//   clr_counts    : synchronous clear of the statistics counters
//   shot_count    : transferred results, saturating
//   ones_count    : transferred results with class = 1, saturating
// ---------------------------------------------------------------------------
module layer2_output_stage #(
    parameter int N_NEURONS = 16,
    parameter int THRESH    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    layer2_output_stage_if.slave  bus,
    input  logic                  clr_counts,
    output logic [CNT_W-1:0]      shot_count,
    output logic [CNT_W-1:0]      ones_count
);
    localparam int PW = $clog2(N_NEURONS + 1);

    function automatic logic [PW-1:0] popcount(input logic [N_NEURONS-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    // FIFO state
    logic [1:0][N_NEURONS-1:0] fifo_q, fifo_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic [1:0]                occ_q, occ_d;

    // S1 / S2
    logic                      s1_vld_q, s1_vld_d;
    logic [PW-1:0]             s1_pc_q, s1_pc_d;
    logic                      s2_vld_q, s2_vld_d;
    logic [PW-1:0]             s2_pc_q, s2_pc_d;
    logic                      s2_cls_q, s2_cls_d;

    // Statistics
    logic [CNT_W-1:0]          shot_q, shot_d;
    logic [CNT_W-1:0]          ones_q, ones_d;

    logic                      in_ready;
    logic                      push, pop, s2_load, xfer;

    // Readiness comes only from the registered occupancy; it is also held
    // low while reset is applied so nothing is taken during reset.
    assign in_ready = !rst && (occ_q != 2'd2);

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        s1_vld_d = s1_vld_q;
        s1_pc_d  = s1_pc_q;
        s2_vld_d = s2_vld_q;
        s2_pc_d  = s2_pc_q;
        s2_cls_d = s2_cls_q;
        shot_d   = shot_q;
        ones_d   = ones_q;

        push    = bus.in_valid && in_ready;
        xfer    = s2_vld_q && bus.out_ready;
        s2_load = s1_vld_q && (!s2_vld_q || bus.out_ready);
        pop     = (occ_q != 2'd0) && (!s1_vld_q || s2_load);

        if (push) begin
            fifo_d[wr_ptr_q] = bus.in_bits;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;

        // push+pop together keeps the occupancy unchanged
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // S2 empties on a transfer unless refilled from S1 on the same edge
        if (s2_load) begin
            s2_vld_d = 1'b1;
            s2_pc_d  = s1_pc_q;
            s2_cls_d = (s1_pc_q >= PW'(THRESH));
        end else if (xfer) begin
            s2_vld_d = 1'b0;
        end

        if (pop) begin
            s1_vld_d = 1'b1;
            s1_pc_d  = popcount(fifo_q[rd_ptr_q]);
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end

        // clear has priority over a transfer on the same edge
        if (clr_counts) begin
            shot_d = '0;
            ones_d = '0;
        end else if (xfer) begin
            if (shot_q != {CNT_W{1'b1}}) shot_d = shot_q + CNT_W'(1);
            if (s2_cls_q && (ones_q != {CNT_W{1'b1}})) ones_d = ones_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            s1_vld_q <= 1'b0;
            s1_pc_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_pc_q  <= '0;
            s2_cls_q <= 1'b0;
            shot_q   <= '0;
            ones_q   <= '0;
        end else begin
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            s1_vld_q <= s1_vld_d;
            s1_pc_q  <= s1_pc_d;
            s2_vld_q <= s2_vld_d;
            s2_pc_q  <= s2_pc_d;
            s2_cls_q <= s2_cls_d;
            shot_q   <= shot_d;
            ones_q   <= ones_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = s2_vld_q;
    assign bus.out_class    = s2_cls_q;
    assign bus.out_popcount = s2_pc_q;
    assign shot_count       = shot_q;
    assign ones_count       = ones_q;
endmodule

// File: tb/tb_layer2_output_stage.sv
module tb_layer2_output_stage;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_bits = '0;
    logic        out_ready = 1'b0;
    logic        clr_counts = 1'b0;

    always #5 clk = ~clk;

    // two instances on the same stimulus: full-width and 4-bit counters
    layer2_output_stage_if #(.N_NEURONS(N)) ba ();
    layer2_output_stage_if #(.N_NEURONS(N)) bb ();

    assign ba.in_valid  = in_valid;
    assign ba.in_bits   = in_bits;
    assign ba.out_ready = out_ready;
    assign bb.in_valid  = in_valid;
    assign bb.in_bits   = in_bits;
    assign bb.out_ready = out_ready;

    logic [15:0] shot_a, ones_a;
    logic [3:0]  shot_b, ones_b;

    layer2_output_stage #(.N_NEURONS(N), .THRESH(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ba), .clr_counts(clr_counts),
        .shot_count(shot_a), .ones_count(ones_a)
    );
    layer2_output_stage #(.N_NEURONS(N), .THRESH(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bb), .clr_counts(clr_counts),
        .shot_count(shot_b), .ones_count(ones_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // push n copies of v with the consumer always ready, then let it drain
    task automatic run_shots(input logic [15:0] v, input int n);
        int s;
        s = 0;
        out_ready = 1'b1;
        for (int c = 0; c < n + 8; c++) begin
            in_valid = (s < n);
            in_bits  = v;
            #1;
            if (in_valid && ba.in_ready) s++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("shots_sent", s, n);
    endtask

    logic [15:0] vv[4]  = '{16'h00FF, 16'h007F, 16'hFFFF, 16'h0000};
    int          vpc[4] = '{8, 7, 16, 0};
    logic        vcl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic [15:0] bp[6]    = '{16'h0001, 16'h0F0F, 16'hFFFE, 16'h0003, 16'hAAAA, 16'h7FFF};
    int          bp_pc[6] = '{1, 8, 15, 2, 8, 15};

    initial begin
        int idx, oi, sent, rcvd, e, s, base_shot, ones_exp;
        int q[$];
        logic seen, hold_v, hold_c, first_c;
        logic [4:0] hold_pc, first_pc;

        // ---- reset / idle
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", ba.in_ready, 0);
            chk("rst_out_valid", ba.out_valid, 0);
            chk("rst_out_class", ba.out_class, 0);
            chk("rst_out_pc", ba.out_popcount, 0);
            chk("rst_shot", shot_a, 0);
            chk("rst_ones", ones_a, 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", ba.in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_out_valid", ba.out_valid, 0);
        end

        // ---- vote boundary with latency: accept at edge k, visible after k+2
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= 3 && i <= 6) begin
                chk("vote_valid", ba.out_valid, 1);
                chk("vote_pc", ba.out_popcount, vpc[i-3]);
                chk("vote_class", ba.out_class, vcl[i-3]);
            end else begin
                chk("vote_idle", ba.out_valid, 0);
            end
            if (i < 4) begin
                chk("vote_in_ready", ba.in_ready, 1);
                in_valid = 1'b1;
                in_bits  = vv[i];
            end else begin
                in_valid = 1'b0;
                in_bits  = '0;
            end
            @(negedge clk);
        end
        chk("vote_shot", shot_a, 4);
        chk("vote_ones", ones_a, 2);

        // ---- backpressure: 4 shots fit, output held while stalled
        out_ready = 1'b0;
        idx  = 0;
        seen = 1'b0;
        first_pc = '0;
        first_c  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_bits  = bp[idx];
            #1;
            if (ba.in_ready) idx++;
            if (ba.out_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    first_pc = ba.out_popcount;
                    first_c  = ba.out_class;
                end else begin
                    chk("bp_hold_pc", ba.out_popcount, first_pc);
                    chk("bp_hold_class", ba.out_class, first_c);
                end
            end
            @(negedge clk);
        end
        chk("bp_accepted", idx, 4);
        chk("bp_in_ready_low", ba.in_ready, 0);
        chk("bp_stalled_valid", ba.out_valid, 1);

        out_ready = 1'b1;
        oi = 0;
        for (int c = 0; c < 40 && oi < 6; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) in_bits = bp[idx];
            #1;
            if (in_valid && ba.in_ready) idx++;
            if (ba.out_valid) begin
                chk("bp_pc", ba.out_popcount, bp_pc[oi]);
                chk("bp_class", ba.out_class, (bp_pc[oi] >= 8));
                oi++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_drained", oi, 6);
        chk("bp_all_accepted", idx, 6);
        chk("bp_shot", shot_a, 10);

        // ---- random traffic against a FIFO reference model
        sent = 0;
        rcvd = 0;
        hold_v = 1'b0;
        hold_pc = '0;
        hold_c  = 1'b0;
        base_shot = int'(shot_a);
        ones_exp  = int'(ones_a);
        for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_bits   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold_v) begin
                chk("rnd_hold_valid", ba.out_valid, 1);
                chk("rnd_hold_pc", ba.out_popcount, hold_pc);
                chk("rnd_hold_class", ba.out_class, hold_c);
            end
            if (in_valid && ba.in_ready) begin
                q.push_back($countones(in_bits));
                sent++;
            end
            if (ba.out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_pc", ba.out_popcount, e);
                    chk("rnd_class", ba.out_class, (e >= 8));
                    if (e >= 8) ones_exp++;
                end
                rcvd++;
            end
            hold_v  = ba.out_valid && !out_ready;
            hold_pc = ba.out_popcount;
            hold_c  = ba.out_class;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rnd_received", rcvd, 1000);
        chk("rnd_model_empty", q.size(), 0);
        chk("rnd_shot", shot_a, base_shot + 1000);
        chk("rnd_ones", ones_a, ones_exp);

        // ---- saturation on the 4-bit counters, then clear on a transfer edge
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        chk("clr_shot_b", shot_b, 0);
        chk("clr_ones_b", ones_b, 0);
        run_shots(16'hFFFF, 20);
        chk("sat_shot_b", shot_b, 15);
        chk("sat_ones_b", ones_b, 15);
        chk("sat_shot_a", shot_a, 20);
        chk("sat_ones_a", ones_a, 20);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("clrx_pending", ba.out_valid, 1);
        out_ready  = 1'b1;
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        out_ready  = 1'b0;
        chk("clrx_shot_b", shot_b, 0);
        chk("clrx_ones_b", ones_b, 0);
        chk("clrx_shot_a", shot_a, 0);
        chk("clrx_transferred", ba.out_valid, 0);

        // ---- reset with shots in flight
        run_shots(16'h00FF, 2);
        chk("mid_pre_shot", shot_a, 2);
        out_ready = 1'b0;
        s = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (s < 3);
            in_bits  = 16'h0F0F;
            #1;
            if (in_valid && ba.in_ready) s++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_filled", s, 3);
        chk("mid_pre_valid", ba.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_out_valid", ba.out_valid, 0);
        chk("mid_shot_a", shot_a, 0);
        chk("mid_ones_a", ones_a, 0);
        chk("mid_in_ready", ba.in_ready, 1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ba.out_valid) seen = 1'b1;
        end
        chk("mid_no_ghost", seen, 0);
        chk("mid_shot_after", shot_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
